// File: rtl/palette_pkg.sv
// -----------------------------------------------------------------------------
// palette_pkg
// Shared widths and types for the palette lookup path: a 4-bit palette index
// selects one of 16 entries, each a 24-bit RGB colour.
// -----------------------------------------------------------------------------
package palette_pkg;

    localparam int PAL_IDX_W = 4;
    localparam int RGB_W     = 24;

    typedef logic [PAL_IDX_W-1:0] pal_idx_t;
    typedef logic [RGB_W-1:0]     rgb_t;

endpackage : palette_pkg

// File: rtl/palette_arbiter_if.sv
// -----------------------------------------------------------------------------
// palette_arbiter_if
// Bundles the requester side (en/req/req_index/gnt), the palette side
// (pal_index/pal_rgb) and the response side (rsp_valid/rsp_rgb/busy) of the
// palette arbiter.
//   master : environment view (layer engines + palette model drive inputs)
//   slave  : arbiter view
// -----------------------------------------------------------------------------
interface palette_arbiter_if #(
    parameter int N_REQ = 3
);
    import palette_pkg::*;

    logic                         en;
    logic [N_REQ-1:0]             req;
    logic [N_REQ*PAL_IDX_W-1:0]   req_index;
    logic [N_REQ-1:0]             gnt;
    pal_idx_t                     pal_index;
    rgb_t                         pal_rgb;
    logic [N_REQ-1:0]             rsp_valid;
    rgb_t                         rsp_rgb;
    logic                         busy;

    modport master (
        output en, req, req_index, pal_rgb,
        input  gnt, pal_index, rsp_valid, rsp_rgb, busy
    );

    modport slave (
        input  en, req, req_index, pal_rgb,
        output gnt, pal_index, rsp_valid, rsp_rgb, busy
    );

endinterface : palette_arbiter_if

// File: rtl/palette_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches req circularly starting at
// ptr+1 and returns the first set bit as a one-hot grant plus its encoded id.
// Ports:
//   req    in  N         request vector
//   en     in  1         grant enable; low forces an all-zero grant
//   ptr    in  log2(N)   id of the most recent grant (registered by caller)
//   gnt    out N         one-hot grant
//   gnt_id out log2(N)   encoded id of the granted requester (0 if none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int ID_W = $clog2(N);

    logic [ID_W-1:0] cand_s;
    logic            found_s;

    // Circular first-set search beginning just after the last winner.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_id  = {ID_W{1'b0}};
        found_s = 1'b0;
        cand_s  = {ID_W{1'b0}};
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                // The modulo keeps the wrap correct for non-power-of-two N.
                cand_s = ID_W'((int'(ptr) + k) % N);
                if (!found_s && req[cand_s]) begin
                    found_s      = 1'b1;
                    gnt[cand_s]  = 1'b1;
                    gnt_id       = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

endmodule : rr_arbiter

// File: rtl/palette_arbiter.sv
// -----------------------------------------------------------------------------
// palette_arbiter
// Shares one registered 16-entry palette between N_REQ pixel sources. At most
// one lookup is issued per clock, round-robin. A tag pipe of 1+PAL_LATENCY
// stages follows each issued index through the index register and the
// palette, so the RGB coming back is marked one-hot for its requester.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of palette_arbiter_if:
//     en        in   issue enable (in-flight lookups drain regardless)
//     req       in   per-requester request, held until granted
//     req_index in   packed indices, slice i belongs to requester i
//     gnt       out  one-hot grant, combinational
//     pal_index out  registered index to the palette
//     pal_rgb   in   palette RGB
//     rsp_valid out  one-hot owner of the current rsp_rgb
//     rsp_rgb   out  pal_rgb passed through
//     busy      out  any lookup in flight
// -----------------------------------------------------------------------------
module palette_arbiter
    import palette_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int PAL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    palette_arbiter_if.slave  bus
);

    localparam int ID_W  = $clog2(N_REQ);
    // One stage for the index register, PAL_LATENCY for the palette itself.
    localparam int N_STG = PAL_LATENCY + 1;

    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;

    logic [ID_W-1:0]  ptr_q,       ptr_d;
    pal_idx_t         pal_index_q, pal_index_d;
    logic [N_REQ-1:0] tag_q [N_STG];
    logic [N_REQ-1:0] tag_d [N_STG];
    logic             busy_q,      busy_d;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req    (bus.req),
        .en     (bus.en),
        .ptr    (ptr_q),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    // Pointer and index register: both move only when a grant is issued.
    always_comb begin
        ptr_d       = ptr_q;
        pal_index_d = pal_index_q;
        if (|gnt_s) begin
            ptr_d = gnt_id_s;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_s[i]) begin
                    pal_index_d = bus.req_index[i*PAL_IDX_W +: PAL_IDX_W];
                end else begin
                    pal_index_d = pal_index_d;
                end
            end
        end else begin
            ptr_d       = ptr_q;
            pal_index_d = pal_index_q;
        end
    end

    // Tag pipe shifts every cycle; busy is precomputed so it is a flop output.
    always_comb begin
        tag_d[0] = gnt_s;
        for (int s = 1; s < N_STG; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        busy_d = 1'b0;
        for (int s = 0; s < N_STG; s++) begin
            busy_d = busy_d | (|tag_d[s]);
        end
    end

    // State registers; reset drops any lookups already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= ID_W'(N_REQ - 1);
            pal_index_q <= {PAL_IDX_W{1'b0}};
            busy_q      <= 1'b0;
            for (int s = 0; s < N_STG; s++) begin
                tag_q[s] <= {N_REQ{1'b0}};
            end
        end else begin
            ptr_q       <= ptr_d;
            pal_index_q <= pal_index_d;
            busy_q      <= busy_d;
            for (int s = 0; s < N_STG; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign bus.gnt       = gnt_s;
    assign bus.pal_index = pal_index_q;
    assign bus.rsp_valid = tag_q[N_STG-1];
    assign bus.rsp_rgb   = bus.pal_rgb;
    assign bus.busy      = busy_q;

endmodule : palette_arbiter
